stage_memory: RTL and testbench

Pipeline memory stage. It sits between execute and writeback and is the responder for execute's memory-request outputs (is_mem, mem_addr, mem_val, mem_write, out_addr, out_val). Non-memory results pass through in one cycle. Loads and stores are issued on a word-wide req/ack data bus, and the stage stalls upstream until each access completes. It forwards results and flags bus faults.

---
 rtl/stage_memory_pkg.sv | 16 +
 rtl/stage_memory_timer.sv | 27 ++
 rtl/stage_memory.sv | 155 +++++++++++++++
 tb/tb_stage_memory.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/stage_memory_pkg.sv
// stage_memory_pkg: shared definitions for the pipeline memory stage.
//   state_t         - FSM encoding (IDLE / REQ / DONE)
//   REG_NONE        - destination register meaning "no writeback" (bubble)
//   WORD_ALIGN_MASK - clears the byte-offset bits of an address
package stage_memory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0]  REG_NONE        = 4'h0;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/stage_memory_timer.sv
// mem_bus_timer: counts cycles an access has been outstanding.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : force count to 0 (takes priority over enable)
//   enable     : increment count this cycle
//   expired    : count has reached TIMEOUT-1 (last cycle allowed without ack)
module mem_bus_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n)      count <= '0;
        else if (clear)  count <= '0;
        else if (enable) count <= count + 1'b1;
    end

    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/stage_memory.sv
// stage_memory: pipeline memory stage between execute and writeback.
//   Non-memory results pass to writeback with one cycle of latency and are
//   forwarded combinationally. Aligned loads/stores are issued on a registered
//   req/ack bus; upstream is stalled until the access completes (ack or
//   timeout). Misaligned accesses and timeouts set a sticky fault.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   stall_in / stall                writeback back-pressure / hold execute
//   in_addr, in_val                 execute result (in_addr 0 = bubble)
//   is_mem, mem_addr, mem_val,
//   mem_write                       execute memory request
//   bus_req, bus_we, bus_addr,
//   bus_wdata, bus_ack, bus_rdata   word-wide data bus
//   fwd_valid, fwd_addr, fwd_val    forwarding path
//   out_addr, out_val               registered writeback result
//   fault                           sticky misalign / timeout flag
module stage_memory
    import stage_memory_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_in,
    output logic        stall,
    input  logic [3:0]  in_addr,
    input  logic [31:0] in_val,
    input  logic        is_mem,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_val,
    input  logic        mem_write,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        fwd_valid,
    output logic [3:0]  fwd_addr,
    output logic [31:0] fwd_val,
    output logic [3:0]  out_addr,
    output logic [31:0] out_val,
    output logic        fault
);
    state_t      state;
    logic [3:0]  dest;      // REG_NONE for stores, so they retire as bubbles
    logic [31:0] held_val;  // result parked while writeback is stalled

    logic aligned, expired, ack_hit, timed_out, complete;
    logic [31:0] result;

    assign aligned   = (mem_addr & ~WORD_ALIGN_MASK) == 32'd0;
    assign ack_hit   = (state == REQ) && bus_ack;
    // An ack on the final allowed cycle still counts as a normal completion.
    assign timed_out = (state == REQ) && !bus_ack && expired;
    assign complete  = ack_hit || timed_out;
    assign result    = ack_hit ? bus_rdata : 32'd0;

    mem_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state != REQ),
        .enable  (state == REQ),
        .expired (expired)
    );

    // Release execute on the completing cycle so it advances at the same edge
    // the result moves to writeback.
    always_comb begin
        stall = stall_in;
        case (state)
            IDLE:    if (is_mem && aligned) stall = 1'b1;
            REQ:     if (!(complete && !stall_in)) stall = 1'b1;
            default: stall = stall_in;
        endcase
    end

    always_comb begin
        fwd_valid = 1'b0;
        fwd_addr  = REG_NONE;
        fwd_val   = 32'd0;
        if (state == IDLE && !is_mem) begin
            fwd_valid = (in_addr != REG_NONE);
            fwd_addr  = in_addr;
            fwd_val   = in_val;
        end else if (ack_hit) begin
            // dest is non-zero only for loads
            fwd_valid = (dest != REG_NONE);
            fwd_addr  = dest;
            fwd_val   = bus_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            out_addr  <= REG_NONE;
            out_val   <= 32'd0;
            fault     <= 1'b0;
            dest      <= REG_NONE;
            held_val  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!is_mem) begin
                        if (!stall_in) begin
                            out_addr <= in_addr;
                            out_val  <= in_val;
                        end
                    end else if (!aligned) begin
                        fault <= 1'b1;
                        if (!stall_in) out_addr <= REG_NONE;
                    end else begin
                        dest      <= mem_write ? REG_NONE : in_addr;
                        bus_req   <= 1'b1;
                        bus_we    <= mem_write;
                        bus_addr  <= mem_addr & WORD_ALIGN_MASK;
                        bus_wdata <= mem_val;
                        state     <= REQ;
                        if (!stall_in) out_addr <= REG_NONE;
                    end
                end
                REQ: begin
                    if (complete) begin
                        bus_req <= 1'b0;
                        if (timed_out) fault <= 1'b1;
                        if (!stall_in) begin
                            out_addr <= dest;
                            out_val  <= result;
                            state    <= IDLE;
                        end else begin
                            held_val <= result;
                            state    <= DONE;
                        end
                    end else if (!stall_in) begin
                        out_addr <= REG_NONE;
                    end
                end
                DONE: begin
                    if (!stall_in) begin
                        out_addr <= dest;
                        out_val  <= held_val;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// tb_stage_memory: directed vector table for the documented scenarios, then
// randomized traffic checked against a transaction-level reference model.
module tb_stage_memory;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n, stall_in, is_mem, mem_write, bus_ack;
    logic [3:0]  in_addr;
    logic [31:0] in_val, mem_addr, mem_val, bus_rdata;
    logic        stall, bus_req, bus_we, fwd_valid, fault;
    logic [31:0] bus_addr, bus_wdata, fwd_val, out_val;
    logic [3:0]  fwd_addr, out_addr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stage_memory #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .stall(stall),
        .in_addr(in_addr), .in_val(in_val), .is_mem(is_mem),
        .mem_addr(mem_addr), .mem_val(mem_val), .mem_write(mem_write),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_val(fwd_val),
        .out_addr(out_addr), .out_val(out_val), .fault(fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst_n, stall_in;
        logic [3:0]  in_addr;
        logic [31:0] in_val;
        logic        is_mem;
        logic [31:0] mem_addr, mem_val;
        logic        mem_write, bus_ack;
        logic [31:0] bus_rdata;
        logic        chk_comb, chk_stall, e_stall, e_fwd;  // same-cycle outputs
        logic        e_req, e_we;                          // after the edge
        logic [31:0] e_baddr, e_wdata;
        logic [3:0]  e_oaddr;
        logic [31:0] e_oval;
        logic        e_fault;
    } vec_t;

    vec_t tbl[$];

    // ---------------- reference model ----------------
    // Tracks the outstanding access as a transaction: whether one is on the
    // bus, how long it has waited, and whether a finished result is parked.
    bit          m_busy, m_have, m_req, m_we, m_fault;
    int          m_wait;
    logic [3:0]  m_dest, m_oaddr;
    logic [31:0] m_addr, m_wdata, m_held, m_oval;

    task automatic model_reset();
        m_busy = 0; m_have = 0; m_req = 0; m_we = 0; m_fault = 0; m_wait = 0;
        m_dest = 0; m_oaddr = 0; m_addr = 0; m_wdata = 0; m_held = 0; m_oval = 0;
    endtask

    task automatic model_check();
        bit e_st, e_fv, do_st, ack, to;
        logic [3:0] e_fa;
        logic [31:0] e_fval;
        e_fa = 0; e_fval = 0; do_st = 1;
        if (m_busy) begin
            ack = bus_ack;
            to = !ack && (m_wait == TO - 1);
            e_st = !((ack || to) && !stall_in);
            e_fv = ack && (m_dest != 0);
            e_fa = m_dest; e_fval = bus_rdata;
        end else if (m_have) begin
            e_st = 1; e_fv = 0; do_st = stall_in;
        end else if (!is_mem) begin
            e_st = stall_in; e_fv = (in_addr != 0); e_fa = in_addr; e_fval = in_val;
        end else begin
            e_st = stall_in || (mem_addr[1:0] == 2'b00); e_fv = 0;
        end
        if (do_st) chk("rnd_stall", stall, e_st);
        chk("rnd_fwd_valid", fwd_valid, e_fv);
        if (e_fv) begin
            chk("rnd_fwd_addr", fwd_addr, e_fa);
            chk("rnd_fwd_val", fwd_val, e_fval);
        end
        chk("rnd_bus_req", bus_req, m_req);
        if (m_req) begin
            chk("rnd_bus_we", bus_we, m_we);
            chk("rnd_bus_addr", bus_addr, m_addr);
            chk("rnd_bus_wdata", bus_wdata, m_wdata);
        end
        chk("rnd_out_addr", out_addr, m_oaddr);
        if (m_oaddr != 0) chk("rnd_out_val", out_val, m_oval);
        chk("rnd_fault", fault, m_fault);
    endtask

    task automatic model_step();
        bit ack, to;
        if (!rst_n) begin
            model_reset();
        end else if (m_busy) begin
            ack = bus_ack;
            to = !ack && (m_wait == TO - 1);
            if (ack || to) begin
                m_req = 0; m_busy = 0;
                if (to) m_fault = 1;
                m_held = ack ? bus_rdata : 32'd0;
                if (!stall_in) begin m_oaddr = m_dest; m_oval = m_held; end
                else m_have = 1;
            end else begin
                m_wait++;
                if (!stall_in) m_oaddr = 0;
            end
        end else if (m_have) begin
            if (!stall_in) begin m_oaddr = m_dest; m_oval = m_held; m_have = 0; end
        end else if (!is_mem) begin
            if (!stall_in) begin m_oaddr = in_addr; m_oval = in_val; end
        end else if (mem_addr[1:0] != 2'b00) begin
            m_fault = 1;
            if (!stall_in) m_oaddr = 0;
        end else begin
            m_busy = 1; m_wait = 0; m_req = 1;
            m_dest = mem_write ? 4'd0 : in_addr;
            m_we = mem_write; m_addr = mem_addr; m_wdata = mem_val;
            if (!stall_in) m_oaddr = 0;
        end
    endtask

    initial begin
        // rst stl ia iv im maddr mval mw ack rdata | cc cs es ef | req we baddr wdata | oaddr oval fault
        tbl.push_back('{1,0,3,32'h1234,0,0,0,0,0,0,                   1,1,0,1, 0,0,0,0,                   3,32'h1234,0});
        tbl.push_back('{1,0,5,0,1,32'h100,0,0,0,0,                    1,1,1,0, 1,0,32'h100,0,             0,0,0});
        tbl.push_back('{1,0,5,0,1,32'h100,0,0,0,0,                    1,1,1,0, 1,0,32'h100,0,             0,0,0});
        tbl.push_back('{1,0,5,0,1,32'h100,0,0,1,32'hCAFEBABE,         1,1,0,1, 0,0,0,0,                   5,32'hCAFEBABE,0});
        tbl.push_back('{1,0,7,0,1,32'h204,32'hA5A5A5A5,1,0,0,         1,1,1,0, 1,1,32'h204,32'hA5A5A5A5,  0,0,0});
        tbl.push_back('{1,0,7,0,1,32'h204,32'hA5A5A5A5,1,1,0,         1,1,0,0, 0,0,0,0,                   0,0,0});
        tbl.push_back('{1,0,9,0,1,32'h40,0,0,0,0,                     1,1,1,0, 1,0,32'h40,0,              0,0,0});
        tbl.push_back('{1,1,9,0,1,32'h40,0,0,1,32'h11112222,          1,1,1,1, 0,0,0,0,                   0,0,0});
        tbl.push_back('{1,1,0,0,0,0,0,0,0,0,                          1,1,1,0, 0,0,0,0,                   0,0,0});
        tbl.push_back('{1,1,0,0,0,0,0,0,0,0,                          1,1,1,0, 0,0,0,0,                   0,0,0});
        tbl.push_back('{1,0,0,0,0,0,0,0,0,0,                          1,0,0,0, 0,0,0,0,                   9,32'h11112222,0});
        tbl.push_back('{1,0,6,0,1,32'h80,0,0,0,0,                     1,1,1,0, 1,0,32'h80,0,              0,0,0});
        tbl.push_back('{1,0,6,0,1,32'h80,0,0,0,0,                     1,1,1,0, 1,0,32'h80,0,              0,0,0});
        tbl.push_back('{1,0,6,0,1,32'h80,0,0,0,0,                     1,1,1,0, 1,0,32'h80,0,              0,0,0});
        tbl.push_back('{1,0,6,0,1,32'h80,0,0,0,0,                     1,1,1,0, 1,0,32'h80,0,              0,0,0});
        tbl.push_back('{1,0,6,0,1,32'h80,0,0,0,0,                     1,1,0,0, 0,0,0,0,                   6,0,1});
        tbl.push_back('{1,0,2,32'h55,0,0,0,0,0,0,                     1,1,0,1, 0,0,0,0,                   2,32'h55,1});
        tbl.push_back('{0,0,0,0,0,0,0,0,0,0,                          0,0,0,0, 0,0,0,0,                   0,0,0});
        tbl.push_back('{1,0,4,0,1,32'h102,0,0,0,0,                    1,1,0,0, 0,0,0,0,                   0,0,1});
        tbl.push_back('{1,0,1,0,1,32'h300,0,0,0,0,                    1,1,1,0, 1,0,32'h300,0,             0,0,1});
        tbl.push_back('{0,0,1,0,1,32'h300,0,0,0,0,                    0,0,0,0, 0,0,0,0,                   0,0,0});
        tbl.push_back('{1,0,3,32'h77,0,0,0,0,1,32'hDEAD,              1,1,0,1, 0,0,0,0,                   3,32'h77,0});

        rst_n = 0; stall_in = 0; in_addr = 0; in_val = 0; is_mem = 0;
        mem_addr = 0; mem_val = 0; mem_write = 0; bus_ack = 0; bus_rdata = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_bus_req", bus_req, 0);
        chk("reset_out_addr", out_addr, 0);
        chk("reset_out_val", out_val, 0);
        chk("reset_fault", fault, 0);
        chk("reset_bus_addr", bus_addr, 0);

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n; stall_in = tbl[i].stall_in;
            in_addr = tbl[i].in_addr; in_val = tbl[i].in_val; is_mem = tbl[i].is_mem;
            mem_addr = tbl[i].mem_addr; mem_val = tbl[i].mem_val; mem_write = tbl[i].mem_write;
            bus_ack = tbl[i].bus_ack; bus_rdata = tbl[i].bus_rdata;
            @(negedge clk);
            if (tbl[i].chk_comb) begin
                if (tbl[i].chk_stall) chk($sformatf("vec%0d_stall", i), stall, tbl[i].e_stall);
                chk($sformatf("vec%0d_fwd_valid", i), fwd_valid, tbl[i].e_fwd);
            end
            @(posedge clk); #1;
            chk($sformatf("vec%0d_bus_req", i), bus_req, tbl[i].e_req);
            if (tbl[i].e_req) begin
                chk($sformatf("vec%0d_bus_we", i), bus_we, tbl[i].e_we);
                chk($sformatf("vec%0d_bus_addr", i), bus_addr, tbl[i].e_baddr);
                if (tbl[i].e_we) chk($sformatf("vec%0d_bus_wdata", i), bus_wdata, tbl[i].e_wdata);
            end
            chk($sformatf("vec%0d_out_addr", i), out_addr, tbl[i].e_oaddr);
            if (tbl[i].e_oaddr != 0) chk($sformatf("vec%0d_out_val", i), out_val, tbl[i].e_oval);
            chk($sformatf("vec%0d_fault", i), fault, tbl[i].e_fault);
        end

        // randomized traffic; first cycle resets both DUT and model
        model_reset();
        for (int c = 0; c < 800; c++) begin
            rst_n     = (c == 0) ? 1'b0 : ($urandom_range(149) != 0);
            stall_in  = ($urandom_range(3) == 0);
            is_mem    = ($urandom_range(4) < 2);
            mem_addr  = $urandom & 32'h0000_03FC;
            if ($urandom_range(6) == 0) mem_addr = mem_addr | 32'($urandom_range(3, 1));
            mem_val   = $urandom;
            mem_write = $urandom_range(1);
            in_addr   = 4'($urandom_range(15));
            in_val    = $urandom;
            bus_ack   = m_busy && ($urandom_range(2) == 0);
            bus_rdata = $urandom;
            @(negedge clk);
            if (c != 0) model_check();
            @(posedge clk);
            model_step();
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
